// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared bus codes, FSM state encoding and command legality check
// Purpose: common definitions for AHB-Lite initiators.
// Contents: htrans/hsize/hburst code enums, initiator state enum, cmd_bad().
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR4  = 3'b011
  } hburst_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PIPE,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // A command is illegal if the size is unsupported, the start address is not
  // aligned to the beat size, or an INCR4 does not start on a 4-beat boundary
  // (which also guarantees the burst never crosses a 1 KB boundary).
  function automatic logic cmd_bad(input logic [2:0] size, input logic [31:0] addr,
                                   input logic incr4);
    logic bad;
    bad = 1'b0;
    case (size)
      HSIZE_BYTE: bad = incr4 && (addr[1:0] != 2'b00);
      HSIZE_HALF: bad = addr[0] || (incr4 && (addr[2:0] != 3'b000));
      HSIZE_WORD: bad = (addr[1:0] != 2'b00) || (incr4 && (addr[3:0] != 4'h0));
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// rtl/ahb_lane_align.sv - byte-lane placement of write data and extraction of read data
// Purpose: combinational lane steering for 32-bit AHB data buses.
// Ports: size/offset select the lanes; wdata (right-aligned) -> wdata_bus (lane-placed);
//        rdata_bus (lane-placed) -> rdata (right-aligned, zero-extended).
module ahb_lane_align
  import ahb_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_bus,
  output logic [31:0] wdata_bus,
  output logic [31:0] rdata
);

  logic [31:0] rshift;

  always_comb begin
    wdata_bus = wdata;
    rdata     = rdata_bus;
    rshift    = rdata_bus;
    case (size)
      HSIZE_BYTE: begin
        wdata_bus = {24'h0, wdata[7:0]} << {offset, 3'b000};
        rshift    = rdata_bus >> {offset, 3'b000};
        rdata     = {24'h0, rshift[7:0]};
      end
      HSIZE_HALF: begin
        wdata_bus = {16'h0, wdata[15:0]} << {offset[1], 4'b0000};
        rshift    = rdata_bus >> {offset[1], 4'b0000};
        rdata     = {16'h0, rshift[15:0]};
      end
      default: begin
        wdata_bus = wdata;
        rdata     = rdata_bus;
      end
    endcase
  end

endmodule

// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - AHB-Lite initiator issuing SINGLE or INCR4 transfers per command
// Purpose: accepts one command at a time, runs it on the bus with pipelined
//          address/data phases, wait states and two-cycle ERROR handling, then
//          reports completion with a done/err pulse.
// Ports: hclk/hreset (sync, active high); cmd_* request interface with cmd_ready;
//        rd_valid/rd_data read beat stream; done/err completion; h* AHB-Lite
//        master signals plus add_offset (haddr[1:0] of the current address phase).
module ahb_master
  import ahb_pkg::*;
(
  input  logic         hclk,
  input  logic         hreset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [31:0]  cmd_addr,
  input  logic [2:0]   cmd_size,
  input  logic         cmd_incr4,
  input  logic [127:0] cmd_wdata,
  output logic         rd_valid,
  output logic [31:0]  rd_data,
  output logic         done,
  output logic         err,
  output logic         hsel,
  output logic [31:0]  haddr,
  output logic [1:0]   htrans,
  output logic         hwrite,
  output logic [2:0]   hsize,
  output logic [2:0]   hburst,
  output logic [1:0]   add_offset,
  output logic [31:0]  hwdata,
  input  logic         hready,
  input  logic         hresp,
  input  logic [31:0]  hrdata
);

  state_t state, state_nx;

  // Address-phase beat (a_*) and data-phase beat (d_*) are tracked separately
  // because the two overlap by one beat in PIPE.
  logic [31:0]  a_addr;
  logic [1:0]   a_cnt;
  logic [1:0]   d_off;
  logic [1:0]   d_cnt;
  logic [2:0]   size_q;
  logic         write_q;
  logic         incr4_q;
  logic [127:0] wdata_q;

  logic         accept;
  logic         in_ap;
  logic         in_dp;
  logic         ap_done;
  logic         dp_ok;
  logic [31:0]  beat_wdata;
  logic [31:0]  lane_wdata;
  logic [31:0]  lane_rdata;

  assign accept  = cmd_valid && (state == ST_IDLE);
  assign in_ap   = (state == ST_ADDR) || (state == ST_PIPE);
  assign in_dp   = (state == ST_PIPE) || (state == ST_LAST) || (state == ST_ERR1);
  // An ERROR in PIPE cancels the address phase that is on the bus with it.
  assign ap_done = in_ap && hready && !((state == ST_PIPE) && hresp);
  assign dp_ok   = ((state == ST_PIPE) || (state == ST_LAST)) && hready && !hresp;

  assign beat_wdata = wdata_q[{d_cnt, 5'b00000} +: 32];
  assign add_offset = haddr[1:0];

  ahb_lane_align u_align (
    .size      (size_q),
    .offset    (d_off),
    .wdata     (beat_wdata),
    .rdata_bus (hrdata),
    .wdata_bus (lane_wdata),
    .rdata     (lane_rdata)
  );

  always_ff @(posedge hclk) begin
    if (hreset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nx = cmd_bad(cmd_size, cmd_addr, cmd_incr4) ? ST_ERR2 : ST_ADDR;
      ST_ADDR: if (hready) state_nx = incr4_q ? ST_PIPE : ST_LAST;
      ST_PIPE: begin
        if (hresp)                          state_nx = hready ? ST_ERR2 : ST_ERR1;
        else if (hready && (a_cnt == 2'd3)) state_nx = ST_LAST;
      end
      ST_LAST: begin
        if (hresp)       state_nx = hready ? ST_ERR2 : ST_ERR1;
        else if (hready) state_nx = ST_IDLE;
      end
      ST_ERR1: if (hready) state_nx = ST_ERR2;
      ST_ERR2: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    hsel      = in_ap || in_dp;
    htrans    = HTRANS_IDLE;
    haddr     = 32'h0;
    hwrite    = 1'b0;
    hsize     = 3'd0;
    hburst    = 3'd0;
    hwdata    = 32'h0;
    if (state == ST_ADDR)      htrans = HTRANS_NONSEQ;
    else if (state == ST_PIPE) htrans = HTRANS_SEQ;
    if (in_ap) begin
      haddr  = a_addr;
      hwrite = write_q;
      hsize  = size_q;
      hburst = incr4_q ? HBURST_INCR4 : HBURST_SINGLE;
    end
    if (in_dp && write_q) hwdata = lane_wdata;
    // ERR2 covers both rejected commands and the end of an ERROR response.
    done = ((state == ST_LAST) && hready && !hresp) || (state == ST_ERR2);
    err  = (state == ST_ERR2);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      a_addr   <= 32'h0;
      a_cnt    <= 2'd0;
      d_off    <= 2'd0;
      d_cnt    <= 2'd0;
      size_q   <= 3'd0;
      write_q  <= 1'b0;
      incr4_q  <= 1'b0;
      wdata_q  <= 128'h0;
      rd_valid <= 1'b0;
      rd_data  <= 32'h0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        a_addr  <= cmd_addr;
        a_cnt   <= 2'd0;
        size_q  <= cmd_size;
        write_q <= cmd_write;
        incr4_q <= cmd_incr4;
        wdata_q <= cmd_wdata;
      end
      if (ap_done) begin
        d_off  <= a_addr[1:0];
        d_cnt  <= a_cnt;
        a_addr <= a_addr + (32'd1 << size_q);
        a_cnt  <= a_cnt + 2'd1;
      end
      if (dp_ok && !write_q) begin
        rd_valid <= 1'b1;
        rd_data  <= lane_rdata;
      end
    end
  end

endmodule

// File: doc/ahb_master.md
# ahb_master

AHB-Lite initiator that turns single-command requests from local control logic into SINGLE or INCR4 bus transfers toward our AHB slaves (hsel/htrans/hready/hresp pipeline). Handles pipelined address/data phases, wait states, the two-cycle ERROR response, and byte-lane placement/extraction via add_offset. One command runs at a time, and completion is reported with a done/err pulse.

## Interface
- No parameters: address width is 32, data width is 32, and the burst cap is 4 beats (fixed).
- hclk  in  1  bus clock; all logic on the rising edge.
- hreset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  start byte address.
- cmd_size  in  3  0 = byte, 1 = half, 2 = word.
- cmd_incr4  in  1  0 = SINGLE, 1 = INCR4.
- cmd_wdata  in  128  beat i data in bits [32i+:32], right-aligned; latched at accept.
- rd_valid  out  1  one-cycle pulse per completed read beat.
- rd_data  out  32  right-aligned, zero-extended read beat.
- done  out  1  one-cycle pulse at command end.
- err  out  1  valid with done; 1 = slave ERROR or rejected command.
- hsel  out  1  high while a command is on the bus.
- haddr  out  32  bus address.
- htrans  out  2  transfer type.
- hwrite  out  1  write flag.
- hsize  out  3  transfer size.
- hburst  out  3  burst type.
- add_offset  out  2  haddr[1:0] of the current address phase.
- hwdata  out  32  lane-placed write data.
- hready  in  1  slave hreadyout.
- hresp  in  1  1 = ERROR.
- hrdata  in  32  slave read data.

## Operation
- States: IDLE, ADDR, PIPE, LAST, ERR1, ERR2.
- Acceptance and rejection:
  - A command is accepted on cmd_valid & cmd_ready.
  - It is rejected, with done=1 and err=1 on the next cycle and no bus activity, if any of these hold:
    - cmd_size>2;
    - the address is misaligned to the size;
    - cmd_incr4 is set and cmd_addr is not aligned to 4<<cmd_size.
- ADDR:
  - Drives beat 0: htrans=NONSEQ (2'b10), hburst = SINGLE 3'b000 or INCR4 3'b011, hsize, hwrite, haddr, add_offset, hsel=1.
  - When hready is high, moves to PIPE (remaining beats) or LAST.
- PIPE:
  - Drives beat i+1: htrans=SEQ (2'b11), haddr += 1<<size.
  - Beat i is in its data phase at the same time.
  - Advances only when hready is high; all address-phase outputs hold while hready is low.
- LAST:
  - Data phase of the final beat; htrans=IDLE.
  - On hready: pulse done, err=0, then return to IDLE.
- Write data:
  - Beat data is shifted onto lanes: byte to lane addr[1:0], half to lane addr[1].
  - hwdata is valid for the whole data phase and holds through wait states.
- Read data:
  - Sampled when hready is high during a data phase.
  - The lane is extracted and right-aligned to rd_data, with rd_valid pulsed.
- Errors:
  - hresp=1 & hready=0 in any data phase → ERR1: htrans=IDLE next cycle, remaining beats cancelled.
  - hresp=1 & hready=1 → ERR2 action: pulse done with err=1, then IDLE.
  - Beats completed before the error keep their rd_valid pulses.
- Reset at any point: all state and outputs go to reset values at the next edge; no done pulse.

## Timing
- Reset values:
  - htrans=0, haddr=0, hwrite=0, hsize=0, hburst=0, hsel=0, add_offset=0, hwdata=0.
  - done=0, err=0, rd_valid=0, rd_data=0.
  - cmd_ready=1 (state IDLE).
- Accept at edge N gives NONSEQ on the bus in cycle N+1.
- Zero wait states:
  - SINGLE: done in cycle N+2.
  - INCR4: done in cycle N+5.
- Each hready-low cycle adds exactly one cycle.
- cmd_ready returns high the cycle after done.
- rd_valid asserts the cycle after the sampling edge; rd_data holds until the next beat.

## Structure
- Package ahb_pkg:
  - htrans codes IDLE/BUSY/NONSEQ/SEQ;
  - hsize codes BYTE/HALF/WORD;
  - hburst codes SINGLE/INCR4;
  - state enum.
- Sub-module ahb_lane_align (combinational): place write data / extract read data from size and offset; shared with future initiators.
- Beat counter: 2 bits. Address incrementer: 32 bits, no 1 KB crossing possible given the alignment rule.

## Test plan
- SINGLE word write to 0x10 with data 0xDEADBEEF, zero wait → NONSEQ with haddr=0x10 in cycle N+1, hwdata=0xDEADBEEF in N+2, done=1, err=0.
- INCR4 word read from 0x40, slave inserts 2 wait states on beat 1 → haddr 0x40/0x44/0x48/0x4C; four rd_valid pulses in order; done in N+7.
- Byte write of 0xA5 to 0x103 → add_offset=3, hwdata=0xA5000000; half read at 0x102 returning 0x12340000 → rd_data=0x00001234.
- INCR4 write where the slave returns ERROR on beat 1 (hresp 1/0 then 1/1) → htrans=IDLE after the first error cycle, beats 2–3 never issued, done with err=1.
- Reject: word at 0x2, or INCR4 half at 0x4 → done with err=1 next cycle, htrans stays 0.
- hreset asserted mid-INCR4 → next cycle all outputs at reset values, cmd_ready=1, no done.
